// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the per-channel ADC frame capture block.
package adc_cap_pkg;
  localparam int ADC_W = 14;

  typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, READOUT} cap_state_t;

  typedef struct packed {
    logic [ADC_W-1:0] data;
    logic             ovr;
  } smp_t;

  typedef struct packed {
    logic [ADC_W-1:0] data;
    logic             last;
  } beat_t;

  function automatic logic [ADC_W-1:0] ob2tc(input logic [ADC_W-1:0] x);
    return {~x[ADC_W-1], x[ADC_W-2:0]};
  endfunction
endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module adc_cap_ram #(
  parameter int AW = 10,
  parameter int W  = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/adc_frame_capture.sv
// Per-channel ADC frame capture: pre/post-trigger windows into a circular RAM, streamed out.
// Optional macro ADC_CAP_OVR_CNT_EN adds a saturating overrange cycle counter (ovr_cnt).
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int AW        = 10,
  parameter int PRE_LEN   = 128,
  parameter int POST_LEN  = 384,
  parameter int TWOS_COMP = 1
) (
  input  logic             adc_clk100m,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_or,
  input  logic             arm,
  input  logic             force_trig,
  input  logic [ADC_W-1:0] thresh,
  output logic             busy,
  output logic             done,
  output logic [ADC_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
`ifdef ADC_CAP_OVR_CNT_EN
  output logic [15:0]      ovr_cnt,
`endif
  output logic             frame_ovr
);
  localparam int FRAME = PRE_LEN + POST_LEN;

  cap_state_t       state;
  smp_t             st1, st2;
  logic [ADC_W-1:0] s, thr, prev_s, rd_q;
  logic [AW-1:0]    wr_ptr, rd_ptr, pre_cnt, post_cnt;
  logic [AW:0]      rd_left;
  logic             prev_vld, wr_en, trig, pop, issue, rd_vld, rd_last;
  beat_t [1:0]      skid;
  logic [1:0]       cnt, cnt_nxt;

  assign s       = (TWOS_COMP != 0) ? ob2tc(st2.data) : st2.data;
  assign busy    = (state != IDLE);
  assign wr_en   = (state == PRE_FILL) || (state == ARMED) || (state == POST);
  assign trig    = (state == ARMED) && (force_trig ||
                   (prev_vld && $signed(prev_s) < $signed(thr) && $signed(s) >= $signed(thr)));
  assign pop     = m_valid && m_ready;
  assign cnt_nxt = cnt + 2'(rd_vld) - 2'(pop);
  // Only fetch when the skid buffer is guaranteed a free slot for the returning word.
  assign issue   = (state == READOUT) && (rd_left != '0) && (cnt_nxt < 2'd2);
  assign m_data  = skid[0].data;
  assign m_last  = skid[0].last;

  adc_cap_ram #(.AW(AW), .W(ADC_W)) u_ram (
    .clk(adc_clk100m), .we(wr_en), .wa(wr_ptr), .wd(s),
    .re(issue), .ra(rd_ptr), .rd(rd_q)
  );

  always_ff @(posedge adc_clk100m) begin
    if (rst) begin
      state     <= IDLE;
      st1       <= '0;
      st2       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_left   <= '0;
      thr       <= '0;
      prev_s    <= '0;
      prev_vld  <= 1'b0;
      frame_ovr <= 1'b0;
      done      <= 1'b0;
    end else begin
      st1  <= '{data: adc_data, ovr: adc_or};
      st2  <= st1;
      done <= 1'b0;
      if (wr_en) begin
        wr_ptr    <= wr_ptr + AW'(1);
        frame_ovr <= frame_ovr | st2.ovr;
      end
      case (state)
        IDLE: if (arm) begin
          state     <= PRE_FILL;
          thr       <= thresh;
          frame_ovr <= 1'b0;
          pre_cnt   <= '0;
        end
        PRE_FILL: begin
          pre_cnt  <= pre_cnt + AW'(1);
          prev_vld <= 1'b0;
          if (pre_cnt == AW'(PRE_LEN - 1)) state <= ARMED;
        end
        ARMED: begin
          prev_s   <= s;
          prev_vld <= 1'b1;
          if (trig) begin
            rd_ptr   <= wr_ptr - AW'(PRE_LEN);
            rd_left  <= (AW+1)'(FRAME);
            post_cnt <= AW'(1);
            state    <= (POST_LEN == 1) ? READOUT : POST;
          end
        end
        POST: begin
          post_cnt <= post_cnt + AW'(1);
          if (post_cnt == AW'(POST_LEN - 1)) state <= READOUT;
        end
        READOUT: begin
          if (issue) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_left <= rd_left - (AW+1)'(1);
          end
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer absorbing the RAM read latency.
  always_ff @(posedge adc_clk100m) begin
    if (rst) begin
      skid    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= (rd_left == (AW+1)'(1));
      cnt     <= cnt_nxt;
      m_valid <= (cnt_nxt != 2'd0);
      case (cnt)
        2'd0: if (rd_vld) skid[0] <= '{data: rd_q, last: rd_last};
        2'd1: if (rd_vld) begin
          if (pop) skid[0] <= '{data: rd_q, last: rd_last};
          else     skid[1] <= '{data: rd_q, last: rd_last};
        end
        default: if (pop) begin
          skid[0] <= skid[1];
          if (rd_vld) skid[1] <= '{data: rd_q, last: rd_last};
        end
      endcase
    end
  end

`ifdef ADC_CAP_OVR_CNT_EN
  always_ff @(posedge adc_clk100m) begin
    if (rst) ovr_cnt <= '0;
    else if (state == IDLE && arm) ovr_cnt <= '0;
    else if (wr_en && st2.ovr && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed scoreboard bench for adc_frame_capture (ramp, constant, stall, overrange, reset, re-arm).
module tb_adc_frame_capture;
  localparam int PRE = 128, POST = 384, FRAME = 512;

  logic        adc_clk100m = 1'b0;
  logic        rst = 1'b1, adc_or = 1'b0, arm = 1'b0, force_trig = 1'b0, m_ready = 1'b1;
  logic [13:0] adc_data = '0, thresh = '0;
  logic        busy, done, m_valid, m_last, frame_ovr;
  logic [13:0] m_data;
`ifdef ADC_CAP_OVR_CNT_EN
  logic [15:0] ovr_cnt;
`endif

  always #5 adc_clk100m = ~adc_clk100m;

  adc_frame_capture #(.AW(10), .PRE_LEN(PRE), .POST_LEN(POST), .TWOS_COMP(1)) dut (
    .adc_clk100m(adc_clk100m), .rst(rst), .adc_data(adc_data), .adc_or(adc_or),
    .arm(arm), .force_trig(force_trig), .thresh(thresh), .busy(busy), .done(done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
`ifdef ADC_CAP_OVR_CNT_EN
    .ovr_cnt(ovr_cnt),
`endif
    .frame_ovr(frame_ovr)
  );

  int          checks = 0, errors = 0;
  logic [13:0] exp_q [$];
  int          mode = 0, rdy_mode = 0, beat_idx = 0, cyc_n = 0, first_hs = 0, last_hs = 0;
  logic [13:0] ramp_ob = '0, const_ob = '0, prev_data = '0;
  bit          exp_done = 0, done_seen = 0, prev_stall = 0, prev_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the negedge (inputs for the next posedge already applied), then advance one clock.
  task automatic cyc();
    logic [13:0] e;
    if (done === 1'b1 || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
    if (done === 1'b1) done_seen = 1;
    exp_done = 0;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_last", 32'(m_last), 32'(prev_last));
    end
    if (m_valid === 1'b1 && m_ready && !rst) begin
      if (exp_q.size() == 0) chk("extra_beat", 32'(m_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_data), 32'(e));
        chk("beat_last", 32'(m_last), 32'(beat_idx == FRAME - 1));
      end
      if (beat_idx == 0) first_hs = cyc_n;
      last_hs = cyc_n;
      beat_idx++;
      if (m_last === 1'b1) exp_done = 1;
    end
    prev_stall = (m_valid === 1'b1) && !m_ready && !rst;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge adc_clk100m);
    @(negedge adc_clk100m);
    cyc_n++;
    if (mode == 0) begin adc_data = ramp_ob; ramp_ob = ramp_ob + 14'd1; end
    else adc_data = const_ob;
    if (rdy_mode == 0) m_ready = 1'b1;
    else if (cyc_n % 64 < 32) m_ready = ~m_ready;
    else m_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic arm_frame(input logic [13:0] thr);
    thresh = thr; arm = 1'b1; beat_idx = 0;
    cyc();
    arm = 1'b0;
  endtask

  task automatic push_ramp();
    for (int k = -PRE; k < POST; k++) exp_q.push_back(14'(k));
  endtask

  task automatic push_const(input logic [13:0] v);
    for (int k = 0; k < FRAME; k++) exp_q.push_back(v);
  endtask

  task automatic run_frame(input string tag);
    done_seen = 0;
    for (int i = 0; i < 20000 && !done_seen; i++) cyc();
    chk({tag, "_done"}, 32'(done_seen), 32'd1);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_ovr"}, 32'(frame_ovr), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
`ifdef ADC_CAP_OVR_CNT_EN
    chk({tag, "_ovr_cnt"}, 32'(ovr_cnt), 32'd0);
`endif
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    beat_idx = 0; exp_done = 0;
  endtask

  task automatic start_ramp(input int first);
    mode = 0; ramp_ob = 14'(first + 8192);
  endtask

  initial begin
    @(negedge adc_clk100m);
    cycles(3);
    rst = 1'b0;
    chk_reset("reset");

    // 1: full ramp, threshold 0, continuous ready, no bubbles
    start_ramp(-8192); cycles(2);
    push_ramp(); arm_frame(14'd0);
    cyc();
    chk("t1_busy", 32'(busy), 32'd1);
    run_frame("t1");
    chk("t1_no_bubble", 32'(last_hs - first_hs), 32'(FRAME - 1));
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: constant 100, force_trig well after ARMED
    mode = 1; const_ob = 14'(100 + 8192); cycles(3);
    push_const(14'd100); arm_frame(14'd200);
    cycles(180); force_trig = 1'b1; cyc(); force_trig = 1'b0;
    run_frame("t2");
    chk("t2_frame_ovr", 32'(frame_ovr), 32'd0);

    // 3: ramp with toggling/random ready; force_trig during PRE_FILL must be ignored
    start_ramp(-700); rdy_mode = 1; cycles(2);
    push_ramp(); arm_frame(14'd0);
    cycles(5); force_trig = 1'b1; cycles(3); force_trig = 1'b0;
    run_frame("t3");
    rdy_mode = 0; cycles(2);

    // 4: one-cycle overrange during POST
    mode = 1; cycles(2);
    push_const(14'd100); arm_frame(14'd200);
    cycles(180); force_trig = 1'b1; cyc(); force_trig = 1'b0;
    cycles(20); adc_or = 1'b1; cyc(); adc_or = 1'b0;
    run_frame("t4");
    chk("t4_frame_ovr", 32'(frame_ovr), 32'd1);
`ifdef ADC_CAP_OVR_CNT_EN
    chk("t4_ovr_cnt", 32'(ovr_cnt), 32'd1);
`endif

    // 5: reset mid-POST and mid-READOUT, then a clean frame
    push_const(14'd100); arm_frame(14'd200);
    chk("t5_arm_clears_ovr", 32'(frame_ovr), 32'd0);
`ifdef ADC_CAP_OVR_CNT_EN
    chk("t5_arm_clears_ovr_cnt", 32'(ovr_cnt), 32'd0);
`endif
    cycles(180); force_trig = 1'b1; cyc(); force_trig = 1'b0;
    cycles(100);
    pulse_rst();
    chk_reset("t5_rst_post");
    push_const(14'd100); arm_frame(14'd200);
    cycles(180); force_trig = 1'b1; cyc(); force_trig = 1'b0;
    for (int i = 0; i < 2000 && beat_idx < 100; i++) cyc();
    chk("t5_reached_readout", 32'(beat_idx >= 100), 32'd1);
    pulse_rst();
    chk_reset("t5_rst_readout");
    start_ramp(-400); rdy_mode = 1; cycles(2);
    push_ramp(); arm_frame(14'd0);
    run_frame("t5");
    rdy_mode = 0;

    // 6: arm during ARMED (with a new threshold) and during READOUT is ignored
    start_ramp(-1000); cycles(2);
    push_ramp(); arm_frame(14'd0);
    cycles(200);
    thresh = 14'(-700); arm = 1'b1; cyc(); arm = 1'b0; thresh = 14'd0;
    for (int i = 0; i < 5000 && beat_idx < 50; i++) cyc();
    chk("t6_reached_readout", 32'(beat_idx >= 50), 32'd1);
    arm = 1'b1; cyc(); arm = 1'b0;
    run_frame("t6");
    cycles(40);
    chk("t6_stays_idle", 32'(busy), 32'd0);
    chk("t6_no_more_valid", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
